// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard
// Purpose  : Register file with 2 bypassed read ports, 1 write port, optional
//            hardwired r0 and a per-register pending-write hazard scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   rr1,
    input  logic [ADDR_W-1:0]   rr2,
    output logic [DATA_W-1:0]   data1,
    output logic [DATA_W-1:0]   data2,
    input  logic                wen,
    input  logic [ADDR_W-1:0]   wr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic                issue_valid,
    input  logic                issue_wen,
    input  logic [ADDR_W-1:0]   issue_dst,
    input  logic [ADDR_W-1:0]   issue_src1,
    input  logic [ADDR_W-1:0]   issue_src2,
    output logic                issue_stall,
    output logic [NUM_REGS-1:0] pending,
    output logic [CNT_W-1:0]    stall_cnt
);

    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_pending;
    logic [CNT_W-1:0]    r_stall_cnt;

    logic [NUM_REGS-1:0] w_wr_hit;
    logic [NUM_REGS-1:0] w_eff;
    logic [NUM_REGS-1:0] w_set;
    logic                w_stall;
    logic                w_src1_busy;
    logic                w_src2_busy;
    logic                w_dst_busy;

    // Per-register decode; a hardwired r0 can never be written or go pending.
    generate
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
            localparam logic [ADDR_W-1:0] c_idx       = ADDR_W'(i);
            localparam bit                c_hardwired = (ZERO_REG != 0) && (i == 0);

            assign w_wr_hit[i] = wen && (wr == c_idx) && !c_hardwired;
            assign w_eff[i]    = r_pending[i] && !w_wr_hit[i];
            assign w_set[i]    = issue_valid && issue_wen && !w_stall &&
                                 (issue_dst == c_idx) && !c_hardwired;
        end
    endgenerate

    // Out-of-range indices match no entry and therefore read 0 / never stall.
    always_comb begin
        data1       = '0;
        data2       = '0;
        w_src1_busy = 1'b0;
        w_src2_busy = 1'b0;
        w_dst_busy  = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rr1 == ADDR_W'(i)) begin
                data1 = w_wr_hit[i] ? wdata : r_regs[i];
            end
            if (rr2 == ADDR_W'(i)) begin
                data2 = w_wr_hit[i] ? wdata : r_regs[i];
            end
            if (issue_src1 == ADDR_W'(i)) begin
                w_src1_busy = w_eff[i];
            end
            if (issue_src2 == ADDR_W'(i)) begin
                w_src2_busy = w_eff[i];
            end
            if (issue_dst == ADDR_W'(i)) begin
                w_dst_busy = w_eff[i];
            end
        end
    end

    assign w_stall     = issue_valid && (w_src1_busy || w_src2_busy || (issue_wen && w_dst_busy));
    assign issue_stall = w_stall;

    // A new producer claiming a register being written back keeps it pending.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_pending   <= '0;
            r_stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_wr_hit[i]) begin
                    r_regs[i] <= wdata;
                end
                if (w_set[i]) begin
                    r_pending[i] <= 1'b1;
                end else if (w_wr_hit[i]) begin
                    r_pending[i] <= 1'b0;
                end
            end
            if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign pending   = r_pending;
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_scoreboard
// Purpose  : Scoreboard bench for regfile_scoreboard against an array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_scoreboard;

    localparam int CNT_W = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  rr1 = '0, rr2 = '0, wr = '0;
    logic [4:0]  issue_dst = '0, issue_src1 = '0, issue_src2 = '0;
    logic        wen = 1'b0, issue_valid = 1'b0, issue_wen = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] data1, data2;
    logic        issue_stall;
    logic [31:0] pending;
    logic [CNT_W-1:0] stall_cnt;

    regfile_scoreboard #(
        .DATA_W(32), .NUM_REGS(32), .ADDR_W(5), .ZERO_REG(1), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .rr1(rr1), .rr2(rr2), .data1(data1), .data2(data2),
        .wen(wen), .wr(wr), .wdata(wdata), .issue_valid(issue_valid),
        .issue_wen(issue_wen), .issue_dst(issue_dst), .issue_src1(issue_src1),
        .issue_src2(issue_src2), .issue_stall(issue_stall), .pending(pending),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d1;
        logic [31:0] d2;
        logic        stall;
        logic [31:0] pend;
        int          cnt;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   tests  = 0;
    int   fails  = 0;
    int   cyc_no = 0;

    // Architectural model: plain arrays updated once per cycle.
    logic [31:0] m_regs [32];
    bit          m_pend [32];
    int          m_cnt;

    function automatic bit m_written(int a);
        return wen && (int'(wr) == a) && (a != 0);
    endfunction

    function automatic logic [31:0] m_read(int a);
        if (a == 0) return 32'd0;
        if (m_written(a)) return wdata;
        return m_regs[a];
    endfunction

    function automatic bit m_busy(int a);
        return m_pend[a] && !m_written(a);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end
        m_cnt = 0;
    endtask

    // Inputs are already applied; record the expected response, advance the
    // model, then move to just after the next rising edge.
    task automatic cycle();
        exp_t e;
        bit   st;
        if (!rst) model_reset();
        st = issue_valid && (m_busy(int'(issue_src1)) || m_busy(int'(issue_src2)) ||
                             (issue_wen && m_busy(int'(issue_dst))));
        e.d1    = m_read(int'(rr1));
        e.d2    = m_read(int'(rr2));
        e.stall = st;
        e.cnt   = m_cnt;
        e.cyc   = cyc_no;
        for (int i = 0; i < 32; i++) e.pend[i] = m_pend[i];
        exp_q.push_back(e);
        if (rst) begin
            if (m_written(int'(wr))) begin
                m_regs[wr] = wdata;
                m_pend[wr] = 1'b0;
            end
            if (issue_valid && issue_wen && !st && issue_dst != 0) m_pend[issue_dst] = 1'b1;
            if (st && m_cnt < (1 << CNT_W) - 1) m_cnt++;
        end
        cyc_no++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_issue(bit v, bit w, int d, int s1, int s2);
        issue_valid = v;
        issue_wen   = w;
        issue_dst   = 5'(d);
        issue_src1  = 5'(s1);
        issue_src2  = 5'(s2);
    endtask

    task automatic set_wb(bit en, int a, logic [31:0] d);
        wen   = en;
        wr    = 5'(a);
        wdata = d;
    endtask

    task automatic chk(string name, int cyc, logic [31:0] got, logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, want);
        end
    endtask

    // Monitor: outputs are stable at the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("data1", e.cyc, data1, e.d1);
            chk("data2", e.cyc, data2, e.d2);
            chk("issue_stall", e.cyc, 32'(issue_stall), 32'(e.stall));
            chk("pending", e.cyc, pending, e.pend);
            chk("stall_cnt", e.cyc, 32'(stall_cnt), 32'(e.cnt));
        end
    end

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        // Reset state with rr1=7, rr2=0
        rr1 = 5'd7; rr2 = 5'd0;
        cycle();
        cycle();
        rst = 1'b1;

        // RAW stall on r3, resolved by same-cycle writeback with bypass
        set_issue(1, 1, 3, 1, 2); cycle();
        set_issue(1, 0, 0, 3, 0); rr1 = 5'd3;
        repeat (3) cycle();
        set_wb(1, 3, 32'hDEAD_BEEF); cycle();
        set_wb(0, 0, 0); set_issue(0, 0, 0, 0, 0); cycle();

        // Hardwired r0
        set_wb(1, 0, 32'd5); rr1 = 5'd0; rr2 = 5'd3; cycle();
        set_wb(0, 0, 0); set_issue(1, 1, 0, 3, 3); cycle();
        set_issue(1, 0, 0, 0, 0); cycle();

        // Same-cycle clear and set of r4: set wins
        set_issue(1, 1, 4, 1, 2); cycle();
        set_wb(1, 4, 32'h1234_5678); set_issue(1, 1, 4, 1, 2); rr2 = 5'd4; cycle();
        set_wb(0, 0, 0); set_issue(1, 0, 0, 4, 1); cycle();

        // WAW stall on r6, then asynchronous reset mid-stall
        set_issue(1, 1, 6, 1, 2); cycle();
        set_issue(1, 1, 6, 1, 2); cycle();
        rst = 1'b0; cycle();
        rst = 1'b1; cycle();

        // Stall counter saturation
        set_issue(1, 1, 9, 1, 2); cycle();
        set_issue(1, 0, 0, 9, 0);
        repeat (20) cycle();
        set_wb(1, 9, 32'hA5A5_0009); cycle();
        set_wb(0, 0, 0); set_issue(0, 0, 0, 0, 0);
        rst = 1'b0; cycle();
        rst = 1'b1;

        // Random traffic biased towards a few registers to provoke hazards
        for (int n = 0; n < 400; n++) begin
            int mask;
            mask = ($urandom_range(0, 3) == 0) ? 31 : 7;
            rr1 = 5'($urandom & mask);
            rr2 = 5'($urandom & mask);
            set_wb($urandom_range(0, 2) == 0, int'($urandom & mask), $urandom);
            set_issue($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                      int'($urandom & mask), int'($urandom & mask), int'($urandom & mask));
            rst = ($urandom_range(0, 63) != 0);
            cycle();
        end
        rst = 1'b1;
        set_wb(0, 0, 0); set_issue(0, 0, 0, 0, 0);

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        if (exp_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: got %0d queued expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
